// File: rtl/aclk_keypad_scanner.sv
// 4x3 keypad scanner: column scan, 2-flop row sync, press/release
// debounce and digit encode for the alarm clock key bus.
module aclk_keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [2:0] col_drive,
  output logic [3:0] key,
  output logic       key_valid
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] SETTLE = DW'(2);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [3:0] NOKEY = 4'hA;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_e;

  state_e state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [3:0] cap_pat_q, cap_pat_d;
  logic [1:0] cap_row_q, cap_row_d;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] row_s_q, row_s_d;
  logic [3:0] key_q, key_d;
  logic valid_q, valid_d;

  logic any_low;
  logic [1:0] hit_row;
  logic mappable;
  logic [1:0] col_nxt;
  logic [3:0] digit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SCAN;
      col_q <= 2'd0;
      dwell_q <= '0;
      deb_q <= '0;
      cap_pat_q <= 4'hF;
      cap_row_q <= 2'd0;
      sync1_q <= 4'hF;
      row_s_q <= 4'hF;
      key_q <= NOKEY;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      dwell_q <= dwell_d;
      deb_q <= deb_d;
      cap_pat_q <= cap_pat_d;
      cap_row_q <= cap_row_d;
      sync1_q <= sync1_d;
      row_s_q <= row_s_d;
      key_q <= key_d;
      valid_q <= valid_d;
    end
  end

  // lowest low row wins; '*' and '#' never count as a press
  always_comb begin
    any_low = 1'b0;
    hit_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s_q[r]) begin
        any_low = 1'b1;
        hit_row = 2'(r);
      end
    end
    mappable = any_low && !(hit_row == 2'd3 && col_q != 2'd1);
    col_nxt = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    if (cap_row_q == 2'd3) begin
      digit = 4'd0;
    end else begin
      digit = {2'b00, cap_row_q} * 4'd3 + {2'b00, col_q} + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d = col_q;
    dwell_d = dwell_q;
    deb_d = deb_q;
    cap_pat_d = cap_pat_q;
    cap_row_d = cap_row_q;
    sync1_d = row_in;
    row_s_d = sync1_q;
    key_d = key_q;
    valid_d = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (dwell_q >= SETTLE && mappable) begin
          state_d = DEB_PRESS;
          cap_pat_d = row_s_q;
          cap_row_d = hit_row;
          deb_d = CW'(1);
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          col_d = col_nxt;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEB_PRESS: begin
        if (row_s_q != cap_pat_q) begin
          state_d = SCAN;
          deb_d = '0;
          dwell_d = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          deb_d = '0;
          key_d = digit;
          valid_d = 1'b1;
        end else begin
          deb_d = deb_q + CW'(1);
        end
      end
      PRESSED: begin
        if (row_s_q[cap_row_q]) begin
          state_d = DEB_RELEASE;
          deb_d = CW'(1);
        end
      end
      DEB_RELEASE: begin
        if (!row_s_q[cap_row_q]) begin
          state_d = PRESSED;
          deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = SCAN;
          key_d = NOKEY;
          deb_d = '0;
          dwell_d = '0;
          col_d = col_nxt;
        end else begin
          deb_d = deb_q + CW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign col_drive = ~(3'b001 << col_q);
  assign key = key_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// Bench for aclk_keypad_scanner: keypad matrix model, vector
// table, corner-case sequences and randomized press/release runs.
module tb_aclk_keypad_scanner;

  localparam logic [3:0] NOKEY = 4'hA;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [3:0] row_in;
  logic [2:0] col_drive;
  logic [3:0] key;
  logic key_valid;

  logic pressed [12];
  logic [3:0] keymap [12];

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int dbl_cnt = 0;
  logic prev_v = 1'b0;
  logic [3:0] last_vkey = NOKEY;

  typedef struct {
    int r;
    int c;
    logic [3:0] k;
    int nv;
  } vec_t;

  vec_t tbl [6];

  aclk_keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .row_in(row_in),
    .col_drive(col_drive),
    .key(key),
    .key_valid(key_valid)
  );

  always #5 clock = ~clock;

  // physical matrix: a held key shorts its row to its column
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressed[r*3+c] && !col_drive[c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(posedge clock) begin
    #2;
    if (key_valid) begin
      valid_cnt++;
      last_vkey = key;
      if (prev_v) dbl_cnt++;
    end
    prev_v = key_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_key(input logic [3:0] v, input int budget,
                          output int cyc);
    cyc = -1;
    for (int i = 0; i <= budget && cyc < 0; i++) begin
      if (key === v) cyc = i;
      else @(negedge clock);
    end
  endtask

  task automatic release_all();
    for (int i = 0; i < 12; i++) pressed[i] = 1'b0;
  endtask

  int cyc;
  int v0;
  int seen;
  int pos;
  int hold;
  int nb;

  initial begin
    keymap = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
               4'd7, 4'd8, 4'd9, NOKEY, 4'd0, NOKEY};
    tbl[0] = '{r: 1, c: 1, k: 4'h5, nv: 1};
    tbl[1] = '{r: 3, c: 0, k: NOKEY, nv: 0};
    tbl[2] = '{r: 3, c: 2, k: NOKEY, nv: 0};
    tbl[3] = '{r: 3, c: 1, k: 4'h0, nv: 1};
    tbl[4] = '{r: 0, c: 2, k: 4'h3, nv: 1};
    tbl[5] = '{r: 2, c: 1, k: 4'h8, nv: 1};
    release_all();

    // reset state and idle scan pattern
    repeat (3) @(negedge clock);
    chk("rst_key", key, NOKEY);
    chk("rst_valid", key_valid, 0);
    chk("rst_col", col_drive, 3'b110);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      case (i / 4)
        0: chk("idle_col", col_drive, 3'b110);
        1: chk("idle_col", col_drive, 3'b101);
        default: chk("idle_col", col_drive, 3'b011);
      endcase
      @(negedge clock);
    end
    repeat (20) @(negedge clock);
    chk("idle_key", key, NOKEY);
    chk("idle_valid_cnt", valid_cnt, 0);

    // table vectors
    for (int t = 0; t < 6; t++) begin
      v0 = valid_cnt;
      pressed[tbl[t].r*3+tbl[t].c] = 1'b1;
      if (tbl[t].nv != 0) begin
        wait_key(tbl[t].k, 40, cyc);
        chk("tbl_latency_ok", (cyc >= 0 && cyc <= 31) ? 1 : 0, 1);
        repeat (5) @(negedge clock);
        chk("tbl_key", key, tbl[t].k);
        chk("tbl_valid_cnt", valid_cnt - v0, 1);
        chk("tbl_valid_key", last_vkey, tbl[t].k);
        release_all();
        repeat (17) @(negedge clock);
        chk("tbl_rel_hold", key, tbl[t].k);
        @(negedge clock);
        chk("tbl_rel_done", key, NOKEY);
      end else begin
        seen = 0;
        for (int i = 0; i < 40; i++) begin
          if (col_drive == 3'b011) seen++;
          @(negedge clock);
        end
        chk("tbl_nopress_key", key, NOKEY);
        chk("tbl_nopress_valid", valid_cnt - v0, 0);
        chk("tbl_nopress_scan", (seen > 0) ? 1 : 0, 1);
        release_all();
      end
      repeat (30) @(negedge clock);
    end

    // key 0 with contact bounce
    v0 = valid_cnt;
    for (int i = 0; i < 7; i++) begin
      pressed[10] = (i % 2 == 0);
      repeat (3) @(negedge clock);
    end
    chk("bounce_no_valid", valid_cnt - v0, 0);
    repeat (12) @(negedge clock);
    chk("bounce_stable15", valid_cnt - v0, 0);
    wait_key(4'h0, 60, cyc);
    chk("bounce_found", (cyc >= 0) ? 1 : 0, 1);
    repeat (10) @(negedge clock);
    chk("bounce_valid_cnt", valid_cnt - v0, 1);
    chk("bounce_key", key, 4'h0);
    release_all();
    repeat (40) @(negedge clock);

    // hold 1, add 9, release 1
    v0 = valid_cnt;
    pressed[0] = 1'b1;
    wait_key(4'h1, 40, cyc);
    chk("multi_1_found", (cyc >= 0) ? 1 : 0, 1);
    pressed[8] = 1'b1;
    repeat (30) @(negedge clock);
    chk("multi_1_held", key, 4'h1);
    chk("multi_1_valid", valid_cnt - v0, 1);
    pressed[0] = 1'b0;
    repeat (20) @(negedge clock);
    chk("multi_gap", key, NOKEY);
    wait_key(4'h9, 60, cyc);
    chk("multi_9_found", (cyc >= 0) ? 1 : 0, 1);
    repeat (2) @(negedge clock);
    chk("multi_9_valid", valid_cnt - v0, 2);
    chk("multi_9_vkey", last_vkey, 4'h9);
    release_all();
    repeat (40) @(negedge clock);

    // reset pulse while 7 is held
    pressed[6] = 1'b1;
    wait_key(4'h7, 40, cyc);
    chk("rst7_found", (cyc >= 0) ? 1 : 0, 1);
    repeat (4) @(negedge clock);
    v0 = valid_cnt;
    reset = 1'b0;
    #1;
    chk("rst7_async_key", key, NOKEY);
    chk("rst7_async_col", col_drive, 3'b110);
    chk("rst7_async_valid", key_valid, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    wait_key(4'h7, 40, cyc);
    chk("rst7_reacq", (cyc >= 0) ? 1 : 0, 1);
    repeat (2) @(negedge clock);
    chk("rst7_new_valid", valid_cnt - v0, 1);
    release_all();
    repeat (40) @(negedge clock);

    // randomized presses with short bounces vs keymap reference
    for (int n = 0; n < 24; n++) begin
      pos = $urandom_range(0, 11);
      hold = $urandom_range(45, 90);
      nb = $urandom_range(0, 6);
      v0 = valid_cnt;
      for (int b = 0; b < nb; b++) begin
        pressed[pos] = (b % 2 == 0);
        repeat ($urandom_range(1, 4)) @(negedge clock);
      end
      pressed[pos] = 1'b1;
      repeat (hold) @(negedge clock);
      chk("rnd_key", key, keymap[pos]);
      chk("rnd_valid_cnt", valid_cnt - v0,
          (keymap[pos] == NOKEY) ? 0 : 1);
      if (keymap[pos] != NOKEY) chk("rnd_vkey", last_vkey, keymap[pos]);
      release_all();
      repeat (30) @(negedge clock);
      chk("rnd_release", key, NOKEY);
    end

    chk("valid_one_cycle", dbl_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
